// File: rtl/alu_operand_loader.sv
// alu_operand_loader: assembles WORD_W-wide beats into OP_W-wide A/B operands for the ALU.
// Define ALU_OPERAND_LOADER_SINGLE_EN so that in_single on the first A beat skips LOAD_B and clears B.
module alu_operand_loader #(
   parameter int WORD_W = 32,
   parameter int OP_W   = 128
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_single,
   input  logic              flush,
   output logic [OP_W-1:0]   A,
   output logic [OP_W-1:0]   B,
   output logic              op_valid,
   input  logic              op_ready
);
   localparam int BEATS = OP_W / WORD_W;
   localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
`ifdef ALU_OPERAND_LOADER_SINGLE_EN
   localparam bit SINGLE_EN = 1'b1;
`else
   localparam bit SINGLE_EN = 1'b0;
`endif
   typedef enum logic [1:0] {LOAD_A, LOAD_B, HOLD} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [OP_W-1:0] a_n, b_n;
   logic single_q, single_n, rdy_n, vld_n, take, last, unary;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= LOAD_A;
         cnt      <= '0;
         A        <= '0;
         B        <= '0;
         single_q <= 1'b0;
         in_ready <= 1'b0;
         op_valid <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         A        <= a_n;
         B        <= b_n;
         single_q <= single_n;
         in_ready <= rdy_n;
         op_valid <= vld_n;
      end
   end
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      a_n      = A;
      b_n      = B;
      single_n = single_q;
      take     = in_valid && in_ready;
      last     = cnt == CW'(BEATS - 1);
      // the unary flag of the current A load is the live input on its first beat
      unary    = SINGLE_EN && (cnt == '0 ? in_single : single_q);
      if (flush) begin
         state_n = LOAD_A;
         cnt_n   = '0;
      end else if (state == HOLD) begin
         if (op_ready) state_n = LOAD_A;
      end else if (take) begin
         if (state == LOAD_A) begin
            a_n[cnt*WORD_W +: WORD_W] = in_data;
            if (cnt == '0) single_n = in_single;
         end else begin
            b_n[cnt*WORD_W +: WORD_W] = in_data;
         end
         cnt_n = last ? '0 : cnt + 1'b1;
         if (last) begin
            state_n = (state == LOAD_B || unary) ? HOLD : LOAD_B;
            if (state == LOAD_A && unary) b_n = '0;
         end
      end
      rdy_n = state_n != HOLD;
      vld_n = state_n == HOLD;
   end
endmodule

// File: tb/tb_alu_operand_loader.sv
// tb_alu_operand_loader: randomized and directed checks of alu_operand_loader against a beat-count model.
module tb_alu_operand_loader;
   localparam int W = 32;
   localparam int OP = 128;
   localparam int N = OP / W;
`ifdef ALU_OPERAND_LOADER_SINGLE_EN
   localparam bit SEN = 1'b1;
`else
   localparam bit SEN = 1'b0;
`endif
   logic clk = 1'b0, rst_n = 1'b0;
   logic [W-1:0] in_data = '0;
   logic in_valid = 1'b0, in_single = 1'b0, flush = 1'b0, op_ready = 1'b0;
   logic in_ready, op_valid;
   logic [OP-1:0] A, B;
   int total = 0, bad = 0;
   int got = 0;
   bit hold = 0, live = 0, single = 0, took = 0;
   logic [OP-1:0] ea = '0, eb = '0;
   logic [W-1:0] words [8];

   alu_operand_loader #(.WORD_W(W), .OP_W(OP)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .in_single(in_single), .flush(flush), .A(A), .B(B), .op_valid(op_valid), .op_ready(op_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [OP-1:0] obs, input logic [OP-1:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      got = 0; hold = 0; live = 0; single = 0; ea = '0; eb = '0;
   endtask

   // pair-level model: counts accepted words, first N go to A, the rest to B
   task automatic model_step();
      took = 0;
      if (flush) begin
         got = 0; hold = 0;
      end else if (hold) begin
         if (op_ready) hold = 0;
      end else if (in_valid && live) begin
         took = 1;
         if (got == 0) single = in_single;
         if (got < N) ea[got*W +: W] = in_data;
         else eb[(got-N)*W +: W] = in_data;
         got++;
         if (got == N && SEN && single) begin
            eb = '0; hold = 1; got = 0;
         end else if (got == 2*N) begin
            hold = 1; got = 0;
         end
      end
      live = 1;
   endtask

   task automatic cyc(input logic v, input logic [W-1:0] d, input logic s, input logic f, input logic r);
      chk("in_ready", in_ready, live && !hold);
      chk("op_valid", op_valid, hold);
      chk("A", A, ea);
      chk("B", B, eb);
      in_valid = v; in_data = d; in_single = s; flush = f; op_ready = r;
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic load8();
      for (int k = 0; k < 8; k++) cyc(1'b1, words[k], 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int idx;
      for (int k = 0; k < 8; k++) words[k] = (k + 1) * 32'h11111111;
      @(negedge clk);
      chk("rst_ready", in_ready, 1'b0);
      chk("rst_valid", op_valid, 1'b0);
      chk("rst_A", A, '0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(0, 0, 0, 0, 0);
      load8();
      cyc(0, 0, 0, 0, 0);
      chk("gapless_A", A, 128'h44444444_33333333_22222222_11111111);
      chk("gapless_B", B, 128'h88888888_77777777_66666666_55555555);
      for (int k = 0; k < 5; k++) cyc(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1);
      chk("turn_ready", in_ready, 1'b1);
      chk("turn_valid", op_valid, 1'b0);
      idx = 0;
      for (int c = 0; c < 200 && idx < 8; c++) begin
         cyc(1'($urandom % 2), words[idx], 1'b0, 1'b0, 1'b0);
         if (took) idx++;
      end
      chk("gap_beats", idx, 8);
      cyc(0, 0, 0, 0, 0);
      chk("gap_A", A, 128'h44444444_33333333_22222222_11111111);
      chk("gap_B", B, 128'h88888888_77777777_66666666_55555555);
      cyc(0, 0, 0, 0, 1);
      for (int k = 0; k < 7; k++) cyc(1'b1, 32'hF0 + k, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'hBAD, 1'b0, 1'b1, 1'b0);
      chk("flush_ready", in_ready, 1'b1);
      load8();
      cyc(0, 0, 0, 0, 0);
      chk("flush_B", B, 128'h88888888_77777777_66666666_55555555);
      cyc(0, 0, 0, 0, 1);
      for (int k = 0; k < 6; k++) cyc(1'b1, 32'h100 + k, 1'b0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_A", A, '0);
      chk("arst_B", B, '0);
      chk("arst_ready", in_ready, 1'b0);
      chk("arst_valid", op_valid, 1'b0);
      model_reset();
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cyc(0, 0, 0, 0, 0);
      load8();
      cyc(0, 0, 0, 0, 1);
      cyc(1'b1, 32'hA, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'hD, 1'b0, 1'b0, 1'b0);
      chk("single_valid", op_valid, SEN);
      chk("single_A", A, 128'h0000000D_0000000C_0000000B_0000000A);
      chk("single_B", B, SEN ? 128'h0 : 128'h88888888_77777777_66666666_55555555);
      cyc(0, 0, 0, 1, 0);
      for (int c = 0; c < 400; c++)
         cyc(1'($urandom % 4 != 0), $urandom, 1'($urandom % 3 == 0), 1'($urandom % 25 == 0), 1'($urandom % 2));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
